board_io_ctrl: RTL

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

---
 rtl/board_io_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/board_io_ctrl.sv
// Board I/O helper: clock-enable divider, button synchroniser/debouncer with press pulse, LED polarity driver.
// Define BOARD_IO_DEBOUNCE_EN to build in the per-channel debounce counters.
module board_io_ctrl #(
    parameter int unsigned DIV_MAX        = 1350000,
    parameter int unsigned N_BTN          = 1,
    parameter int unsigned N_LED          = 6,
    parameter int unsigned DB_CYCLES      = 270000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_button,
    input  logic [N_LED-1:0] i_led,
    input  logic             i_div_we,
    input  logic [31:0]      i_div_val,
    output logic             o_tick,
    output logic             o_slow_clk,
    output logic [N_BTN-1:0] o_button,
    output logic [N_BTN-1:0] o_press,
    output logic [N_LED-1:0] o_led
);

    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      div_q, div_d;
    logic             slow_q, slow_d;
    logic             tick_q, tick_d;
    logic [N_BTN-1:0] btn_norm;
    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_LED-1:0] led_q, led_d;

`ifdef BOARD_IO_DEBOUNCE_EN
    localparam int unsigned     DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_q [N_BTN];
    logic [DB_W-1:0] db_cnt_d [N_BTN];
`else
    // Debounce compiled out: DB_CYCLES has no effect on the logic.
    if (DB_CYCLES == 0) begin : g_db_cycles_ignored
    end
`endif

    // A runtime load outranks the terminal count, so a load edge never ticks or toggles.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        cnt_d  = cnt_q + 32'd1;
        div_d  = div_q;
        slow_d = slow_q;
        tick_d = 1'b0;
        if (i_div_we) begin
            div_d = i_div_val;
            cnt_d = '0;
        end else if (cnt_q == div_q) begin
            cnt_d  = '0;
            slow_d = ~slow_q;
            tick_d = 1'b1;
        end
    end

    assign btn_norm = i_button ^ {N_BTN{BTN_ACTIVE_LOW}};

    always_comb begin
        sync1_d = btn_norm;
        sync2_d = sync1_q;
`ifdef BOARD_IO_DEBOUNCE_EN
        stable_d = stable_q;
        for (int i = 0; i < int'(N_BTN); i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
`else
        stable_d = sync2_q;
`endif
        // Registered alongside stable so the pulse lines up with the first pressed cycle.
        press_d = stable_d & ~stable_q;
    end

    assign led_d = i_led ^ {N_LED{LED_ACTIVE_LOW}};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q    <= '0;
            div_q    <= DIV_MAX;
            slow_q   <= 1'b0;
            tick_q   <= 1'b0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            press_q  <= '0;
            led_q    <= {N_LED{LED_ACTIVE_LOW}};
`ifdef BOARD_IO_DEBOUNCE_EN
            // NOTE: the counter array is real control state, so it is reset like any other flop.
            db_cnt_q <= '{default: '0};
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            slow_q   <= slow_d;
            tick_q   <= tick_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            led_q    <= led_d;
`ifdef BOARD_IO_DEBOUNCE_EN
            db_cnt_q <= db_cnt_d;
`endif
        end
    end

    assign o_tick     = tick_q;
    assign o_slow_clk = slow_q;
    assign o_button   = stable_q;
    assign o_press    = press_q;
    assign o_led      = led_q;

endmodule
